// File: rtl/sat_pkg.sv
// sat_pkg: literal codes, reader state and clause-beat types
// shared by the clause reader, the popcount helper and the bin loader
package sat_pkg;

  localparam logic [1:0] LIT_NONE = 2'd0;
  localparam logic [1:0] LIT_POS  = 2'd1;
  localparam logic [1:0] LIT_NEG  = 2'd2;
  localparam logic [1:0] LIT_BAD  = 2'd3;

  localparam int DEF_NUM_CLAUSES = 8;
  localparam int DEF_NUM_VARS    = 8;
  localparam int DEF_WIDTH_C_LEN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_NEXT,
    S_DONE
  } rd_state_e;

  typedef struct packed {
    logic [$clog2(DEF_NUM_CLAUSES)-1:0] index;
    logic [DEF_WIDTH_C_LEN-1:0]         len;
    logic [2*DEF_NUM_VARS-1:0]          lits;
  } clause_beat_t;

endpackage

// File: rtl/lit_popcount.sv
// lit_popcount: counts nonzero literal codes and flags illegal code 3
// ports: lits_i literal vector, len_o nonzero count, bad_o any code 3
module lit_popcount
  import sat_pkg::*;
#(
  parameter int NUM_VARS    = DEF_NUM_VARS,
  parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN
) (
  input  logic [NUM_VARS*2-1:0]  lits_i,
  output logic [WIDTH_C_LEN-1:0] len_o,
  output logic                   bad_o
);

  always_comb begin
    len_o = '0;
    bad_o = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      unique case (lits_i[2*i +: 2])
        LIT_NONE: ;
        LIT_POS,
        LIT_NEG: len_o = len_o + WIDTH_C_LEN'(1);
        LIT_BAD: begin
          // illegal codes still occupy a literal slot
          len_o = len_o + WIDTH_C_LEN'(1);
          bad_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/clause_array_reader.sv
// clause_array_reader: drains clause slots one by one to a valid/ready sink
// ports: start_i/busy_o/done_o control, rd_o/clause_i array side, out_* beat
module clause_array_reader
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES = DEF_NUM_CLAUSES,
  parameter int NUM_VARS    = DEF_NUM_VARS,
  parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN,
  parameter int SKIP_EMPTY  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  output logic [NUM_CLAUSES-1:0]           rd_o,
  input  logic [NUM_VARS*2-1:0]            clause_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [$clog2(NUM_CLAUSES)-1:0]   out_index_o,
  output logic [WIDTH_C_LEN-1:0]           out_len_o,
  output logic [NUM_VARS*2-1:0]            out_clause_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [$clog2(NUM_CLAUSES+1)-1:0] count_o,
  output logic                             err_o
);

  localparam int IW = $clog2(NUM_CLAUSES);
  localparam int CW = $clog2(NUM_CLAUSES + 1);

  rd_state_e              state_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_nx;
  logic [NUM_CLAUSES-1:0] rd_q;
  logic [NUM_VARS*2-1:0]  lits_q;
  logic [IW-1:0]          index_q;
  logic [WIDTH_C_LEN-1:0] len_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CW-1:0]          count_q;
  logic                   err_q;

  logic [WIDTH_C_LEN-1:0] pc_len;
  logic                   pc_bad;

  lit_popcount #(
    .NUM_VARS   (NUM_VARS),
    .WIDTH_C_LEN(WIDTH_C_LEN)
  ) u_pc (
    .lits_i(clause_i),
    .len_o (pc_len),
    .bad_o (pc_bad)
  );

  assign idx_nx = idx_q + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rd_q    <= '0;
      lits_q  <= '0;
      index_q <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            rd_q    <= NUM_CLAUSES'(1);
          end
        end
        S_ISSUE: begin
          rd_q    <= '0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // array data arrives one cycle after the select
          lits_q  <= clause_i;
          index_q <= idx_q;
          len_q   <= pc_len;
          err_q   <= err_q | pc_bad;
          if (SKIP_EMPTY != 0 && pc_len == '0) begin
            state_q <= S_NEXT;
          end else begin
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            count_q <= count_q + CW'(1);
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == IW'(NUM_CLAUSES - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_nx;
            rd_q    <= NUM_CLAUSES'(1) << idx_nx;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_o         = rd_q;
  assign out_valid_o  = valid_q;
  assign out_index_o  = index_q;
  assign out_len_o    = len_q;
  assign out_clause_o = lits_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign count_o      = count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_clause_array_reader.sv
// tb_clause_array_reader: directed + random drains against a slot-level model
// dut 0 skips empty slots, dut 1 transfers every slot
module tb_clause_array_reader;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start [2] = '{1'b0, 1'b0};
  logic            rdy   [2] = '{1'b1, 1'b1};
  logic [NC-1:0]   rd    [2];
  logic [2*NV-1:0] cl    [2];
  logic            vld   [2];
  logic [2:0]      oidx  [2];
  logic [LW-1:0]   olen  [2];
  logic [2*NV-1:0] olits [2];
  logic            busy  [2];
  logic            done  [2];
  logic [3:0]      cnt   [2];
  logic            err   [2];

  logic [2*NV-1:0] mem [NC];

  typedef struct {
    int              idx;
    int              len;
    logic [2*NV-1:0] lits;
  } beat_t;

  beat_t expq[$];
  int comps = 0;
  int fails = 0;
  int hs [2] = '{0, 0};
  int dn [2] = '{0, 0};
  int stall_left = 0;
  int stall_slot = -1;
  int rmode = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    clause_array_reader #(
      .NUM_CLAUSES(NC),
      .NUM_VARS   (NV),
      .WIDTH_C_LEN(LW),
      .SKIP_EMPTY (g == 0 ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start[g]),
      .rd_o        (rd[g]),
      .clause_i    (cl[g]),
      .out_valid_o (vld[g]),
      .out_ready_i (rdy[g]),
      .out_index_o (oidx[g]),
      .out_len_o   (olen[g]),
      .out_clause_o(olits[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .count_o     (cnt[g]),
      .err_o       (err[g])
    );

    // registered clause_array: junk unless a slot is selected
    always @(posedge clk) begin
      int s;
      s = -1;
      for (int i = 0; i < NC; i++) if (rd[g][i]) s = i;
      cl[g] <= (s >= 0) ? mem[s] : 16'($urandom);
    end

    logic            pstall = 1'b0;
    logic [2:0]      pidx;
    logic [LW-1:0]   plen;
    logic [2*NV-1:0] plits;

    always @(negedge clk) begin
      beat_t b;
      if (!rst) begin
        pstall = 1'b0;
      end else begin
        chk("rd_onehot", 32'($onehot0(rd[g])), 32'(1));
        if (pstall) begin
          chk("hold_valid", 32'(vld[g]), 32'(1));
          chk("hold_index", 32'(oidx[g]), 32'(pidx));
          chk("hold_len", 32'(olen[g]), 32'(plen));
          chk("hold_lits", 32'(olits[g]), 32'(plits));
          chk("rd_quiet", 32'(rd[g]), 32'(0));
        end
        if (vld[g] && rdy[g]) begin
          hs[g]++;
          chk("beat_expected", 32'(expq.size() != 0), 32'(1));
          if (expq.size() != 0) begin
            b = expq.pop_front();
            chk("beat_index", 32'(oidx[g]), 32'(b.idx));
            chk("beat_len", 32'(olen[g]), 32'(b.len));
            chk("beat_lits", 32'(olits[g]), 32'(b.lits));
          end
        end
        if (done[g]) dn[g]++;
        pstall = vld[g] && !rdy[g];
        pidx   = oidx[g];
        plen   = olen[g];
        plits  = olits[g];
      end
    end
  end

  // sink ready: stall plan for one slot, else high or random
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (g == 0 && stall_left > 0 && vld[0] && int'(oidx[0]) == stall_slot) begin
        rdy[0] = 1'b0;
        stall_left--;
      end else if (rmode == 1) begin
        rdy[g] = 1'($urandom_range(0, 1));
      end else begin
        rdy[g] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*NV-1:0] mk(input int n, input bit bad);
    logic [2*NV-1:0] v;
    int p;
    v = '0;
    while (n > 0) begin
      p = $urandom_range(0, NV - 1);
      if (v[2*p +: 2] == 2'd0) begin
        v[2*p +: 2] = 2'($urandom_range(1, 2));
        n--;
      end
    end
    if (bad) begin
      for (int i = 0; i < NV; i++) begin
        if (v[2*i +: 2] != 2'd0) begin
          v[2*i +: 2] = 2'd3;
          break;
        end
      end
    end
    return v;
  endfunction

  // lens: slot i length in nibble i; bad_slot gets one code 3
  task automatic load(input logic [31:0] lens, input int bad_slot);
    for (int i = 0; i < NC; i++)
      mem[i] = mk(int'(lens[4*i +: 4]), i == bad_slot);
  endtask

  task automatic build(input int g, output int ecnt, output logic eerr);
    beat_t b;
    expq.delete();
    ecnt = 0;
    eerr = 1'b0;
    for (int i = 0; i < NC; i++) begin
      int l;
      l = 0;
      for (int v = 0; v < NV; v++) begin
        logic [1:0] c;
        c = mem[i][2*v +: 2];
        if (c != 2'd0) l++;
        if (c == 2'd3) eerr = 1'b1;
      end
      if (g == 1 || l != 0) begin
        b.idx  = i;
        b.len  = l;
        b.lits = mem[i];
        expq.push_back(b);
        ecnt++;
      end
    end
  endtask

  task automatic rchk(input int g);
    chk("rst_rd", 32'(rd[g]), 32'(0));
    chk("rst_valid", 32'(vld[g]), 32'(0));
    chk("rst_index", 32'(oidx[g]), 32'(0));
    chk("rst_len", 32'(olen[g]), 32'(0));
    chk("rst_lits", 32'(olits[g]), 32'(0));
    chk("rst_busy", 32'(busy[g]), 32'(0));
    chk("rst_done", 32'(done[g]), 32'(0));
    chk("rst_count", 32'(cnt[g]), 32'(0));
    chk("rst_err", 32'(err[g]), 32'(0));
  endtask

  task automatic drain(input int g, input int restart_at,
                       input bit poke_done, input int exp_lat);
    int n;
    int ecnt;
    logic eerr;
    build(g, ecnt, eerr);
    hs[g] = 0;
    dn[g] = 0;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    n = 1;
    chk("busy_start", 32'(busy[g]), 32'(1));
    chk("count_clr", 32'(cnt[g]), 32'(0));
    chk("err_clr", 32'(err[g]), 32'(0));
    while (!done[g] && n < 400) begin
      if (n == restart_at) start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
      n++;
    end
    chk("done_seen", 32'(done[g]), 32'(1));
    if (exp_lat > 0) chk("latency", 32'(n), 32'(exp_lat));
    chk("count_final", 32'(cnt[g]), 32'(ecnt));
    chk("busy_done", 32'(busy[g]), 32'(0));
    chk("err_final", 32'(err[g]), 32'(eerr));
    if (poke_done) start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    chk("done_pulse", 32'(done[g]), 32'(0));
    chk("no_restart", 32'(busy[g]), 32'(0));
    tick();
    chk("still_idle", 32'(busy[g]), 32'(0));
    chk("err_sticky", 32'(err[g]), 32'(eerr));
    chk("hs_count", 32'(hs[g]), 32'(ecnt));
    chk("queue_empty", 32'(expq.size()), 32'(0));
    chk("one_done", 32'(dn[g]), 32'(1));
  endtask

  initial begin
    int n;
    int ec;
    logic ee;
    for (int i = 0; i < NC; i++) mem[i] = '0;
    #2 rst = 1'b0;
    #1;
    rchk(0);
    rchk(1);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // five clauses, three empty slots skipped
    load(32'h0003_3332, -1);
    drain(0, 0, 0, 30);

    // full set, ready high
    load(32'h4423_3332, -1);
    drain(0, 0, 0, 33);

    // slot 2 stalled for five cycles
    stall_slot = 2;
    stall_left = 5;
    drain(0, 0, 0, 38);
    chk("stall_used", 32'(stall_left), 32'(0));
    stall_slot = -1;

    // all empty, with and without skipping
    load(32'h0, -1);
    drain(0, 0, 0, 25);
    drain(1, 0, 0, 33);

    // restart mid-drain and in DONE ignored; code 3 sticky
    load(32'h0003_3332, 3);
    drain(0, 10, 1, 30);
    load(32'h0003_3332, -1);
    drain(0, 0, 0, 30);

    // random contents with random sink ready
    rmode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NC; i++)
        mem[i] = mk($urandom_range(0, NV), $urandom_range(0, 4) == 0);
      drain(r % 2, 0, 0, 0);
    end
    rmode = 0;

    // reset during slot 3 transfer
    load(32'h4423_3332, -1);
    build(0, ec, ee);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!(vld[0] && oidx[0] == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_slot3", 32'(vld[0] && oidx[0] == 3'd3), 32'(1));
    rst = 1'b0;
    #1;
    rchk(0);
    expq.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    drain(0, 0, 0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
